// File: rtl/spi_memory_sync.sv
// SPI slave (CPHA 0) bridging a serial header/data stream onto a synchronous word memory port.
// All SPI pins are oversampled by clk; bursts auto-increment the word address.
module spi_memory_sync #(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          CPOL         = 1'b0
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  _select,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rd,
    output logic                  wr,
    output logic                  busy
);

    localparam int unsigned HDR_BITS = 8 * ((ADDR_WIDTH + 8) / 8);
    localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_HEADER     = 2'd1;
    localparam logic [1:0] ST_DATA_WRITE = 2'd2;
    localparam logic [1:0] ST_DATA_READ  = 2'd3;

    logic sel_s1, sel_s2, sck_s1, sck_s2, sck_prev, mosi_s1, mosi_s2;
    logic [1:0] flush_q;
    logic armed_q;
    logic [1:0] state_q, state_d;
    logic [5:0] cnt_q;
    logic [HDR_BITS-1:0] hdr_q;
    logic [HDR_BITS-1:0] hdr_next;
    logic [DATA_WIDTH-1:0] shift_q, hold_q, data_out_q;
    logic [DATA_WIDTH-1:0] word_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic rd_q, wr_q, rd_pend_q;
    logic sck_edge, lead, trail, capture;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sel_s1   <= 1'b1;
            sel_s2   <= 1'b1;
            sck_s1   <= CPOL;
            sck_s2   <= CPOL;
            sck_prev <= CPOL;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            flush_q  <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sel_s1   <= _select;
            sel_s2   <= sel_s1;
            sck_s1   <= sck;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            mosi_s1  <= mosi;
            mosi_s2  <= mosi_s1;
            flush_q  <= {flush_q[0], 1'b1};
            // A select held low through reset must be seen high before a transfer may start
            armed_q  <= armed_q | (flush_q[1] & sel_s2);
        end
    end

    assign sck_edge  = !sel_s2 && (sck_s2 != sck_prev);
    assign lead      = sck_edge && (sck_s2 != CPOL);
    assign trail     = sck_edge && (sck_s2 == CPOL);
    assign hdr_next  = {hdr_q[HDR_BITS-2:0], mosi_s2};
    assign word_next = {shift_q[DATA_WIDTH-2:0], mosi_s2};

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign capture = rd_q;
        end else begin : g_lat
            logic [READ_LATENCY-1:0] rd_dly_q;
            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) rd_dly_q <= '0;
                else         rd_dly_q <= (rd_dly_q << 1) | READ_LATENCY'(rd_q);
            end
            assign capture = rd_dly_q[READ_LATENCY-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (armed_q && !sel_s2) state_d = ST_HEADER;
            ST_HEADER: if (lead && cnt_q == HDR_LAST)
                           state_d = hdr_next[HDR_BITS-1] ? ST_DATA_WRITE : ST_DATA_READ;
            default:   ;
        endcase
        if (state_q != ST_IDLE && sel_s2) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            data_out_q <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            if (wr_q) addr_q <= addr_q + ADDR_ONE;
            if (rd_pend_q && state_d == ST_DATA_READ) rd_q <= 1'b1;
            if (capture) hold_q <= data_in;
            if (state_d != state_q) begin
                cnt_q   <= '0;
                shift_q <= '0;
                if (state_q == ST_HEADER && state_d != ST_IDLE) begin
                    addr_q <= hdr_next[ADDR_WIDTH-1:0];
                    rd_q   <= (state_d == ST_DATA_READ);
                end
            end else begin
                case (state_q)
                    ST_HEADER: begin
                        if (lead) begin
                            hdr_q <= hdr_next;
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    ST_DATA_WRITE: begin
                        if (lead) begin
                            if (cnt_q == DATA_LAST) begin
                                data_out_q <= word_next;
                                wr_q       <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                shift_q <= word_next;
                                cnt_q   <= cnt_q + 6'd1;
                            end
                        end
                    end
                    ST_DATA_READ: begin
                        if (lead) begin
                            if (cnt_q == DATA_LAST) begin
                                cnt_q     <= '0;
                                addr_q    <= addr_q + ADDR_ONE;
                                rd_pend_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 6'd1;
                            end
                        end else if (trail) begin
                            // Word boundary: the prefetched word is already waiting in hold_q
                            shift_q <= (cnt_q == '0) ? hold_q : (shift_q << 1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign miso     = (state_q == ST_DATA_READ) ? shift_q[DATA_WIDTH-1] : 1'b0;
    assign miso_oe  = !sel_s2;
    assign busy     = (state_q != ST_IDLE);
    assign addr     = addr_q;
    assign data_out = data_out_q;
    assign rd       = rd_q;
    assign wr       = wr_q;

endmodule

// File: tb/tb_spi_memory_sync.sv
// Randomized bench for spi_memory_sync: an SPI master drives bursts, and a transaction-level
// model predicts the memory strobes and read-back bytes.
module tb_spi_memory_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, sel0, sel1, sck_lvl, mosi;
    logic sck0, sck1;
    assign sck0 = sck_lvl;
    assign sck1 = ~sck_lvl;

    logic        miso0, oe0, rd0, wr0, busy0;
    logic [14:0] addr0;
    logic [7:0]  dout0, din0;
    logic        miso1, oe1, rd1, wr1, busy1;
    logic [19:0] addr1;
    logic [15:0] dout1, din1;
    assign din1 = '0;

    int n_checks = 0;
    int n_err    = 0;
    int overlap  = 0;
    logic [31:0] tx_q[$], rx_q[$], wa_q[$], wd_q[$], ra_q[$];

    spi_memory_sync dut0 (
        .clk(clk), ._reset(reset_n), ._select(sel0), .sck(sck0), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .addr(addr0), .data_out(dout0), .data_in(din0),
        .rd(rd0), .wr(wr0), .busy(busy0)
    );

    spi_memory_sync #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .READ_LATENCY(1), .CPOL(1'b1)) dut1 (
        .clk(clk), ._reset(reset_n), ._select(sel1), .sck(sck1), .mosi(mosi),
        .miso(miso1), .miso_oe(oe1), .addr(addr1), .data_out(dout1), .data_in(din1),
        .rd(rd1), .wr(wr1), .busy(busy1)
    );

    // Memory contents; equals addr+0x40 for addresses below 0x100
    function automatic logic [7:0] mem_val(input logic [14:0] a);
        return (a[7:0] + 8'h40) ^ {1'b0, a[14:8]};
    endfunction

    // One-cycle read latency memory
    always @(posedge clk) begin
        if (!reset_n)  din0 <= 8'h00;
        else if (rd0)  din0 <= mem_val(addr0);
    end

    always @(negedge clk) begin
        if (wr0) begin wa_q.push_back(32'(addr0)); wd_q.push_back(32'(dout0)); end
        if (wr1) begin wa_q.push_back(32'(addr1)); wd_q.push_back(32'(dout1)); end
        if (rd0) ra_q.push_back(32'(addr0));
        if (rd1) ra_q.push_back(32'(addr1));
        if ((rd0 && wr0) || (rd1 && wr1)) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int inst, input logic b, output logic r);
        mosi = b;
        repeat (8) @(negedge clk);
        r = (inst == 0) ? miso0 : miso1;
        sck_lvl = 1'b1;
        repeat (8) @(negedge clk);
        sck_lvl = 1'b0;
    endtask

    task automatic xfer(input int inst, input logic [31:0] hdr, input int hl, input int dw,
                        input int nw, input int partial);
        logic        r;
        logic [31:0] w;
        if (inst == 0) sel0 = 1'b0; else sel1 = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < hl; i++) send_bit(inst, hdr[hl-1-i], r);
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < dw; b++) begin
                send_bit(inst, tx_q[k][dw-1-b], r);
                w = {w[30:0], r};
            end
            rx_q.push_back(w);
        end
        for (int b = 0; b < partial; b++) send_bit(inst, 1'($urandom), r);
        repeat (8) @(negedge clk);
        if (inst == 0) sel0 = 1'b1; else sel1 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Caller fills tx_q with the words to send before calling
    task automatic txn(input int inst, input bit wflag, input logic [31:0] start, input int nw,
                       input int partial, input logic [31:0] junk);
        int          aw, dw, hl;
        logic [31:0] amask, hdr, a;
        logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_rx[$];
        aw    = (inst == 0) ? 15 : 20;
        dw    = (inst == 0) ? 8 : 16;
        hl    = (inst == 0) ? 16 : 24;
        amask = (32'd1 << aw) - 32'd1;
        hdr   = (32'(wflag) << (hl - 1)) | junk | (start & amask);
        for (int i = 0; i < nw; i++) begin
            a = (start + 32'(i)) & amask;
            if (wflag) begin
                exp_wa.push_back(a);
                exp_wd.push_back(tx_q[i]);
            end else begin
                exp_rx.push_back(32'(mem_val(a[14:0])));
            end
        end
        if (!wflag) for (int i = 0; i <= nw; i++) exp_ra.push_back((start + 32'(i)) & amask);
        wa_q.delete(); wd_q.delete(); ra_q.delete(); rx_q.delete();
        xfer(inst, hdr, hl, dw, nw, partial);
        check("wr_count", 64'(wa_q.size()), 64'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), (i < wa_q.size()) ? wa_q[i] : 32'hFFFF_FFFF,
                  exp_wa[i]);
            check($sformatf("wr_data[%0d]", i), (i < wd_q.size()) ? wd_q[i] : 32'hFFFF_FFFF,
                  exp_wd[i]);
        end
        check("rd_count", 64'(ra_q.size()), 64'(exp_ra.size()));
        for (int i = 0; i < exp_ra.size(); i++)
            check($sformatf("rd_addr[%0d]", i), (i < ra_q.size()) ? ra_q[i] : 32'hFFFF_FFFF,
                  exp_ra[i]);
        for (int i = 0; i < nw; i++) begin
            if (wflag) check($sformatf("miso_idle[%0d]", i), rx_q[i], 0);
            else       check($sformatf("miso_byte[%0d]", i), rx_q[i], exp_rx[i]);
        end
        check("busy_after", (inst == 0) ? busy0 : busy1, 0);
    endtask

    initial begin
        logic [31:0] hdr;
        logic        r;
        int          nw;
        reset_n = 1'b0; sel0 = 1'b1; sel1 = 1'b1; sck_lvl = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_rd", rd0, 0);
        check("rst_wr", wr0, 0);
        check("rst_addr", addr0, 0);
        check("rst_dout", dout0, 0);
        check("rst_miso", miso0, 0);
        check("rst_oe", oe0, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed bursts
        tx_q.delete(); tx_q.push_back(32'hAA); tx_q.push_back(32'h55);
        txn(0, 1'b1, 32'h0123, 2, 0, 0);
        tx_q.delete();
        txn(0, 1'b0, 32'h0010, 3, 0, 0);
        tx_q.delete(); tx_q.push_back(32'h3C); tx_q.push_back(32'hC3);
        txn(0, 1'b1, 32'h7FFF, 2, 0, 0);
        tx_q.delete();
        txn(0, 1'b1, 32'h0001, 0, 5, 0);
        tx_q.delete(); tx_q.push_back(32'h0F);
        txn(0, 1'b1, 32'h0002, 1, 0, 0);
        tx_q.delete();
        txn(0, 1'b0, 32'h7FFE, 3, 0, 0);

        // Random bursts, biased toward the top of the address space
        for (int t = 0; t < 14; t++) begin
            nw = 1 + int'($urandom % 3);
            tx_q.delete();
            for (int i = 0; i < nw; i++) tx_q.push_back($urandom & 32'hFF);
            txn(0, 1'($urandom), ($urandom % 4 == 0) ? 32'h7FFD + ($urandom % 3) : $urandom,
                nw, ($urandom % 4 == 0) ? 1 + int'($urandom % 7) : 0, 0);
        end

        // Wide instance: 20-bit address, 16-bit words, CPOL=1
        tx_q.delete(); tx_q.push_back(32'h1234);
        txn(1, 1'b1, 32'h0ABCD, 1, 0, 0);
        tx_q.delete(); tx_q.push_back($urandom & 32'hFFFF); tx_q.push_back($urandom & 32'hFFFF);
        txn(1, 1'b1, 32'hFFFFF, 2, 0, ($urandom & 32'h7) << 20);
        tx_q.delete(); tx_q.push_back($urandom & 32'hFFFF);
        txn(1, 1'b1, $urandom, 1, 0, ($urandom & 32'h7) << 20);

        // Reset in the middle of a read burst
        sel0 = 1'b0;
        repeat (4) @(negedge clk);
        hdr = 32'h0010;
        for (int i = 0; i < 16; i++) send_bit(0, hdr[15-i], r);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, r);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_rd", rd0, 0);
        check("midrst_wr", wr0, 0);
        check("midrst_addr", addr0, 0);
        check("midrst_dout", dout0, 0);
        check("midrst_miso", miso0, 0);
        check("midrst_oe", oe0, 0);
        check("midrst_busy", busy0, 0);
        ra_q.delete(); wa_q.delete();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(0, 1'($urandom), r);
        check("no_rd_after_rst", 64'(ra_q.size()), 0);
        check("no_wr_after_rst", 64'(wa_q.size()), 0);
        check("idle_after_rst", busy0, 0);
        sel0 = 1'b1;
        repeat (8) @(negedge clk);
        tx_q.delete();
        txn(0, 1'b0, 32'h0020, 2, 0, 0);

        check("rd_wr_exclusive", 64'(overlap), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
